// File: rtl/multiband_eq.sv
// multiband_eq: parallel bank of biquad bands summed through per-band gains.
// Ports:
//   clk        system clock; all state changes on its rising edge
//   reset      asynchronous, active-low reset
//   l_r_clk    I2S frame clock, asynchronous; each rising edge requests one sample
//   audio_in   signed input sample, Q2.(DATA_W-2)
//   audio_out  signed equalised sample, registered
//   out_valid  one-cycle pulse when audio_out updates
//   coef_we    coefficient write strobe; coef_addr = band*5 + {b0,b1,b2,a1,a2}
//   coef_data  coefficient write data
//   gain_we    gain write strobe; gain_addr = band index
//   gain_data  gain write data
//   bypass     sampled with the input; when set the sample passes through unfiltered
//   busy       high while a sample is being computed
//   overrun    sticky; set when a sample request arrives while busy
module multiband_eq #(
   parameter int NUM_BANDS = 3,
   parameter int DATA_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     l_r_clk,
   input  logic signed [DATA_W-1:0] audio_in,
   output logic signed [DATA_W-1:0] audio_out,
   output logic                     out_valid,
   input  logic                     coef_we,
   input  logic [5:0]               coef_addr,
   input  logic signed [DATA_W-1:0] coef_data,
   input  logic                     gain_we,
   input  logic [2:0]               gain_addr,
   input  logic signed [DATA_W-1:0] gain_data,
   input  logic                     bypass,
   output logic                     busy,
   output logic                     overrun
);
   localparam int FRAC = DATA_W - 2;
   localparam int ACC_W = 2 * DATA_W + 4;
   localparam logic signed [DATA_W-1:0] ONE = DATA_W'(1 << FRAC);

   typedef enum logic [1:0] {IDLE, MAC, GAIN, OUT} state_t;

   // round to nearest, drop FRAC bits, clamp to the sample range
   function automatic logic signed [DATA_W-1:0] rnd_sat(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] r;
      r = (a + ACC_W'(1 << (FRAC - 1))) >>> FRAC;
      return (&r[ACC_W-1:DATA_W-1] || ~|r[ACC_W-1:DATA_W-1]) ? r[DATA_W-1:0]
             : {r[ACC_W-1], {(DATA_W-1){~r[ACC_W-1]}}};
   endfunction

   state_t state;
   logic [2:0] sync, band, idx;
   logic rise, byp;
   logic [5:0] cidx;
   logic signed [DATA_W-1:0] x_cap, mul_a, mul_b, y;
   logic signed [DATA_W-1:0] coef [5*NUM_BANDS];
   logic signed [DATA_W-1:0] gain [NUM_BANDS];
   // shadows are sized for the widest configuration so the band/idx selects are exact
   logic signed [DATA_W-1:0] scoef [40];
   logic signed [DATA_W-1:0] sgain [8];
   logic signed [DATA_W-1:0] x1 [8], x2 [8], y1 [8], y2 [8];
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0] prod_x, acc, oacc;

   // single shared multiplier: coefficient x tap during MAC, gain x band output during GAIN
   always_comb begin
      rise = sync[1] & ~sync[2];
      cidx = {3'b0, band} * 6'd5 + {3'b0, idx};
      y = rnd_sat(acc);
      mul_a = state == GAIN ? sgain[band] : scoef[cidx];
      mul_b = state == GAIN ? y : idx == 3'd0 ? x_cap : idx == 3'd1 ? x1[band] :
              idx == 3'd2 ? x2[band] : idx == 3'd3 ? y1[band] : y2[band];
      prod = mul_a * mul_b;
      prod_x = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync <= '0;
         state <= IDLE;
         band <= '0;
         idx <= '0;
         x_cap <= '0;
         byp <= 1'b0;
         acc <= '0;
         oacc <= '0;
         audio_out <= '0;
         out_valid <= 1'b0;
         busy <= 1'b0;
         overrun <= 1'b0;
         for (int i = 0; i < 5 * NUM_BANDS; i++) coef[i] <= i % 5 == 0 ? ONE : '0;
         for (int i = 0; i < NUM_BANDS; i++) gain[i] <= i == 0 ? ONE : '0;
         for (int i = 0; i < 40; i++) scoef[i] <= i % 5 == 0 ? ONE : '0;
         for (int i = 0; i < 8; i++) begin
            sgain[i] <= i == 0 ? ONE : '0;
            x1[i] <= '0;
            x2[i] <= '0;
            y1[i] <= '0;
            y2[i] <= '0;
         end
      end else begin
         sync <= {sync[1:0], l_r_clk};
         out_valid <= 1'b0;
         // out-of-range addresses match no register and are dropped
         for (int i = 0; i < 5 * NUM_BANDS; i++)
            if (coef_we && coef_addr == 6'(i)) coef[i] <= coef_data;
         for (int i = 0; i < NUM_BANDS; i++)
            if (gain_we && gain_addr == 3'(i)) gain[i] <= gain_data;
         if (rise && busy) overrun <= 1'b1;
         case (state)
            IDLE: if (rise) begin
               x_cap <= audio_in;
               byp <= bypass;
               band <= '0;
               idx <= '0;
               oacc <= '0;
               busy <= 1'b1;
               state <= MAC;
               // a write landing in the capture cycle goes straight into the shadow
               for (int i = 0; i < 5 * NUM_BANDS; i++)
                  scoef[i] <= (coef_we && coef_addr == 6'(i)) ? coef_data : coef[i];
               for (int i = 0; i < NUM_BANDS; i++)
                  sgain[i] <= (gain_we && gain_addr == 3'(i)) ? gain_data : gain[i];
            end
            MAC: begin
               acc <= (idx == 3'd0 ? '0 : acc) + (idx > 3'd2 ? -prod_x : prod_x);
               idx <= idx == 3'd4 ? 3'd0 : idx + 3'd1;
               state <= idx == 3'd4 ? GAIN : MAC;
            end
            GAIN: begin
               oacc <= oacc + prod_x;
               if (!byp) begin
                  x2[band] <= x1[band];
                  x1[band] <= x_cap;
                  y2[band] <= y1[band];
                  y1[band] <= y;
               end
               band <= band + 3'd1;
               state <= band == 3'(NUM_BANDS - 1) ? OUT : MAC;
            end
            OUT: begin
               audio_out <= byp ? x_cap : rnd_sat(oacc);
               out_valid <= 1'b1;
               busy <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
